// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and constants for the PC sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } pc_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: priority select of the next PC (jump_reg > jump > branch > sequential).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module next_pc_sel
  import pc_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] j_pc;
  pc_sel_t     sel;

  assign seq_pc = pc + PC_STEP;
  assign br_pc  = seq_pc + (branch_off << 2);
  // J-type keeps the 256 MB region of the delay-slot address
  assign j_pc   = {seq_pc[31:28], jump_target, 2'b00};

  always_comb begin
    sel = SEL_SEQ;
    if (jump_reg)          sel = SEL_JR;
    else if (jump)         sel = SEL_J;
    else if (branch_taken) sel = SEL_BR;
  end

  always_comb begin
    next_pc = seq_pc;
    case (sel)
      SEL_JR:  next_pc = reg_target;
      SEL_J:   next_pc = j_pc;
      SEL_BR:  next_pc = br_pc;
      default: next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, fetches over req/ack, retires via exec_done. Option: PC_ALIGN_CHECK_EN.
// Latency: 1 FETCH cycle (0-wait memory) + >=1 EXEC cycle, so 2 cycles/instr minimum.
// Backpressure: imem_req held until imem_ack (timeout -> HALT); stall holds retirement in EXEC.
module pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic        fault
);

  localparam int            TW         = $clog2(FETCH_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(FETCH_TIMEOUT - 1);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [31:0] raw_next;
  logic [31:0] pc_new;
  logic        align_bad;

  next_pc_sel u_next_pc_sel (
    .pc           (pc_q),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump         (jump),
    .jump_target  (jump_target),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .next_pc      (raw_next)
  );

`ifdef PC_ALIGN_CHECK_EN
  assign align_bad = |raw_next[1:0];
  assign pc_new    = raw_next;
`else
  assign align_bad = 1'b0;
  assign pc_new    = raw_next & ~32'h3;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    timer_d = timer_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          timer_d = '0;
          state_d = EXEC;
        end else if (timer_q == TIMER_LAST) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      EXEC: begin
        if (exec_done && !stall) begin
          valid_d = 1'b0;
          if (align_bad) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            pc_d    = pc_new;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
        state_d = HALT;
      end
    endcase
  end

  // Gated by reset_n so the request drops the instant reset asserts
  assign imem_req    = reset_n && (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;

endmodule
